// File: rtl/axis_hist_accum.sv
// AXI4-Stream histogram accumulator with an internal ping-pong bin RAM.
// One bank counts the current frame through a 3-stage RMW pipeline; the other is held for the reader.
module axis_hist_accum #(
  parameter int DATA_WIDTH  = 16,
  parameter int BIN_BITS    = 14,
  parameter int CNT_WIDTH   = 18,
  parameter int FRAME_LINES = 512
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  hist_rdy,
  input  logic                  hist_upd,
  input  logic [BIN_BITS-1:0]   rd_addr,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic                  hist_sat,
  output logic                  frame_drop
);

  localparam int DEPTH = 1 << BIN_BITS;
  localparam int LW    = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam logic [LW-1:0]        LAST_LINE = LW'(FRAME_LINES - 1);
  localparam logic [CNT_WIDTH-1:0] CMAX      = {CNT_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_WAIT  = 3'd1,
    S_ACC   = 3'd2,
    S_FLUSH = 3'd3,
    S_SKIP  = 3'd4,
    S_CLR   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [BIN_BITS-1:0]   clr_addr_q, clr_addr_d;
  logic [LW-1:0]         line_q, line_d;
  logic                  flush_q, flush_d;
  logic                  restart_q, restart_d;
  logic                  drop_d, swap;
  logic                  acc_sel_q, hist_rdy_q, hist_sat_q, frame_drop_q, sat_acc_q;
  logic                  rb_clr_q;
  logic [BIN_BITS-1:0]   rb_addr_q;
  logic                  rb_free, beat, cnt_beat, eof;
  logic [BIN_BITS-1:0]   bin;

  logic                  s1_vld_q, s2_vld_q;
  logic [BIN_BITS-1:0]   s1_bin_q, s2_bin_q;
  logic [CNT_WIDTH-1:0]  s2_cnt_q;
  logic [CNT_WIDTH-1:0]  s1_old, s1_new;
  logic                  s1_sat;

  logic [1:0]                 we;
  logic [1:0][BIN_BITS-1:0]   waddr, raddr;
  logic [1:0][CNT_WIDTH-1:0]  wdata;
  logic [CNT_WIDTH-1:0]       rdata [2];

  assign bin = s_axis_tdata[DATA_WIDTH-1 -: BIN_BITS];

  if (DATA_WIDTH > BIN_BITS) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^s_axis_tdata[DATA_WIDTH-BIN_BITS-1:0];
  end

  assign s_axis_tready = (state_q == S_WAIT) || (state_q == S_ACC) || (state_q == S_SKIP);
  assign beat     = s_axis_tvalid & s_axis_tready;
  assign cnt_beat = beat & (((state_q == S_WAIT) & s_axis_tuser) | ((state_q == S_ACC) & ~s_axis_tuser));
  assign eof      = cnt_beat & s_axis_tlast & (line_q == LAST_LINE);
  assign rb_free  = ~hist_rdy_q & ~rb_clr_q;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    line_d     = line_q;
    flush_d    = flush_q;
    restart_d  = restart_q;
    drop_d     = 1'b0;
    swap       = 1'b0;
    if (cnt_beat && s_axis_tlast) line_d = eof ? '0 : line_q + 1'b1;
    case (state_q)
      S_INIT, S_CLR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == '1) state_d = S_WAIT;
      end
      S_WAIT: if (cnt_beat) state_d = eof ? S_FLUSH : S_ACC;
      S_ACC: begin
        // A second start-of-frame abandons the partial frame.
        if (beat && s_axis_tuser) begin
          state_d   = S_FLUSH;
          restart_d = 1'b1;
          drop_d    = 1'b1;
          line_d    = '0;
        end else if (eof) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        flush_d = ~flush_q;
        if (flush_q) begin
          restart_d = 1'b0;
          if (restart_q) state_d = S_CLR;
          else if (rb_free) begin
            swap    = 1'b1;
            state_d = S_WAIT;
          end else begin
            drop_d  = 1'b1;
            state_d = S_SKIP;
          end
        end
      end
      S_SKIP: if (beat && s_axis_tuser && rb_free) state_d = S_CLR;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      state_q      <= S_INIT;
      clr_addr_q   <= '0;
      line_q       <= '0;
      flush_q      <= 1'b0;
      restart_q    <= 1'b0;
      acc_sel_q    <= 1'b0;
      hist_rdy_q   <= 1'b0;
      hist_sat_q   <= 1'b0;
      frame_drop_q <= 1'b0;
      sat_acc_q    <= 1'b0;
      rb_clr_q     <= 1'b0;
      rb_addr_q    <= '0;
      s1_vld_q     <= 1'b0;
      s2_vld_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      line_q       <= line_d;
      flush_q      <= flush_d;
      restart_q    <= restart_d;
      frame_drop_q <= drop_d;
      s1_vld_q     <= cnt_beat;
      s2_vld_q     <= s1_vld_q;
      if (swap) acc_sel_q <= ~acc_sel_q;
      if (state_q == S_WAIT && cnt_beat) sat_acc_q <= 1'b0;
      else if (s1_vld_q && s1_sat)       sat_acc_q <= 1'b1;
      if (rb_clr_q) begin
        rb_addr_q <= rb_addr_q + 1'b1;
        if (rb_addr_q == '1) rb_clr_q <= 1'b0;
      end
      // Release starts a background wipe of the read bank; it is only free once that finishes.
      if (hist_upd && hist_rdy_q) begin
        hist_rdy_q <= 1'b0;
        hist_sat_q <= 1'b0;
        rb_clr_q   <= 1'b1;
        rb_addr_q  <= '0;
      end else if (swap) begin
        hist_rdy_q <= 1'b1;
        hist_sat_q <= sat_acc_q;
      end
    end
    s1_bin_q <= bin;
    s2_bin_q <= s1_bin_q;
    s2_cnt_q <= s1_new;
  end

  // S2 is written this cycle, so a same-bin beat in S1 must take its count instead of the RAM.
  always_comb begin
    s1_old = (s2_vld_q && (s2_bin_q == s1_bin_q)) ? s2_cnt_q : rdata[acc_sel_q];
    s1_sat = (s1_old == CMAX);
    s1_new = s1_sat ? s1_old : s1_old + 1'b1;
  end

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      if (1'(b) == acc_sel_q) begin
        raddr[b] = bin;
        we[b]    = (state_q == S_INIT) || (state_q == S_CLR) || s2_vld_q;
        waddr[b] = ((state_q == S_INIT) || (state_q == S_CLR)) ? clr_addr_q : s2_bin_q;
        wdata[b] = ((state_q == S_INIT) || (state_q == S_CLR)) ? '0 : s2_cnt_q;
      end else begin
        raddr[b] = rd_addr;
        we[b]    = (state_q == S_INIT) || rb_clr_q;
        waddr[b] = (state_q == S_INIT) ? clr_addr_q : rb_addr_q;
        wdata[b] = '0;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    logic [CNT_WIDTH-1:0] mem [DEPTH];
    logic [CNT_WIDTH-1:0] rd_q;
    // Write-first bypass covers a read issued on the same edge as the S2 write.
    always_ff @(posedge s_axis_aclk) begin
      if (we[g]) mem[waddr[g]] <= wdata[g];
      rd_q <= (we[g] && (waddr[g] == raddr[g])) ? wdata[g] : mem[raddr[g]];
    end
    assign rdata[g] = rd_q;
  end

  assign hist_rdy   = hist_rdy_q;
  assign hist_sat   = hist_sat_q;
  assign frame_drop = frame_drop_q;
  assign rd_data    = hist_rdy_q ? rdata[~acc_sel_q] : '0;

endmodule

// File: tb/tb_axis_hist_accum.sv
// Directed bench for axis_hist_accum: 256 bins, 11-bit counters, 4-line frames.
module tb_axis_hist_accum;
  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] tdata = '0;
  logic        tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
  logic        tready;
  logic        hist_rdy, hist_upd = 1'b0;
  logic [7:0]  rd_addr = '0;
  logic [10:0] rd_data;
  logic        hist_sat, frame_drop;
  int          errors = 0, checks = 0, drops = 0;
  int          st, d0;

  always #5 clk = ~clk;
  always @(posedge clk) if (frame_drop) drops <= drops + 1;

  axis_hist_accum #(.DATA_WIDTH(16), .BIN_BITS(8), .CNT_WIDTH(11), .FRAME_LINES(4)) dut (
    .s_axis_aclk(clk), .s_axis_aresetn(aresetn), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .s_axis_tlast(tlast), .s_axis_tuser(tuser), .hist_rdy(hist_rdy),
    .hist_upd(hist_upd), .rd_addr(rd_addr), .rd_data(rd_data), .hist_sat(hist_sat),
    .frame_drop(frame_drop));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic u, input logic l, output int stall);
    stall = 0;
    @(negedge clk);
    tdata = d; tvalid = 1'b1; tuser = u; tlast = l;
    while (!tready && stall < 5000) begin
      @(negedge clk);
      stall++;
    end
    if (!tready) chk("tready_wait", tready, 1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  // n beats split into 4 lines; first beat carries tuser.
  task automatic send_frame(input logic [15:0] base, input logic inc, input int n, output int stalls);
    int len, s;
    logic last;
    len = n / 4;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1) || (((i + 1) % len == 0) && ((i + 1) / len < 4));
      send(base + (inc ? 16'(i) : 16'd0), i == 0, last, s);
      stalls += s;
    end
    idle();
  endtask

  task automatic wait_rdy(input string tag);
    int t = 0;
    while (!hist_rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(tag, hist_rdy, 1);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    @(negedge clk) rd_addr = a;
    @(negedge clk) chk(tag, rd_data, exp);
  endtask

  task automatic upd();
    @(negedge clk) hist_upd = 1'b1;
    @(negedge clk) hist_upd = 1'b0;
    chk("rdy_fall", hist_rdy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tready", tready, 0);
    chk("rst_rdy", hist_rdy, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_sat", hist_sat, 0);
    chk("rst_drop", frame_drop, 0);
    aresetn = 1'b1;

    // 1) 4x4 frame, all pixels in bin 0
    send_frame(16'h0000, 1'b1, 16, st);
    wait_rdy("t1_rdy");
    rd_chk("t1_bin0", 8'h00, 16);
    rd_chk("t1_bin1", 8'h01, 0);
    rd_chk("t1_binff", 8'hFF, 0);
    chk("t1_sat", hist_sat, 0);
    upd();
    rd_chk("t1_rd_gated", 8'h00, 0);
    repeat (300) @(negedge clk);

    // 2) full-rate identical bins
    send_frame(16'hABCD, 1'b0, 1024, st);
    chk("t2_stalls", st, 0);
    wait_rdy("t2_rdy");
    rd_chk("t2_binab", 8'hAB, 1024);
    rd_chk("t2_bin0", 8'h00, 0);
    upd();
    repeat (300) @(negedge clk);

    // 3) saturation, then a clean frame clears the flag
    send_frame(16'h1234, 1'b0, 2050, st);
    wait_rdy("t3_rdy");
    rd_chk("t3_bin12", 8'h12, 2047);
    rd_chk("t3_bin0", 8'h00, 0);
    chk("t3_sat", hist_sat, 1);
    upd();
    repeat (300) @(negedge clk);
    send_frame(16'h1200, 1'b1, 16, st);
    wait_rdy("t3b_rdy");
    rd_chk("t3b_bin12", 8'h12, 16);
    chk("t3b_sat", hist_sat, 0);

    // 4) read bank held: next frame dropped
    d0 = drops;
    send_frame(16'h3400, 1'b1, 16, st);
    repeat (10) @(negedge clk);
    chk("t4_drops", drops - d0, 1);
    chk("t4_rdy", hist_rdy, 1);
    rd_chk("t4_bin12", 8'h12, 16);
    rd_chk("t4_bin34", 8'h34, 0);

    // 5) release, leave SKIP with a start beat, then a fresh frame
    upd();
    repeat (300) @(negedge clk);
    send(16'hFFFF, 1'b1, 1'b0, st);
    idle();
    send_frame(16'h5600, 1'b1, 16, st);
    wait_rdy("t5_rdy");
    rd_chk("t5_bin56", 8'h56, 16);
    rd_chk("t5_bin34", 8'h34, 0);
    rd_chk("t5_binff", 8'hFF, 0);
    chk("t5_sat", hist_sat, 0);

    // 5b) start-of-frame inside a frame restarts counting
    upd();
    repeat (300) @(negedge clk);
    d0 = drops;
    for (int i = 0; i < 3; i++) send(16'h7700, i == 0, 1'b0, st);
    send(16'h7800, 1'b1, 1'b0, st);
    idle();
    send_frame(16'h7800, 1'b1, 16, st);
    wait_rdy("t5b_rdy");
    chk("t5b_drops", drops - d0, 1);
    rd_chk("t5b_bin77", 8'h77, 0);
    rd_chk("t5b_bin78", 8'h78, 16);

    // 6) reset mid-frame
    for (int i = 0; i < 5; i++) send(16'h9900, i == 0, 1'b0, st);
    @(negedge clk);
    tvalid = 1'b0; tuser = 1'b0;
    aresetn = 1'b0;
    @(negedge clk);
    chk("t6_tready", tready, 0);
    chk("t6_rdy", hist_rdy, 0);
    chk("t6_rd_data", rd_data, 0);
    aresetn = 1'b1;
    send_frame(16'h9900, 1'b1, 16, st);
    wait_rdy("t6_rdy2");
    rd_chk("t6_bin99", 8'h99, 16);
    rd_chk("t6_bin78", 8'h78, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
